// File: rtl/b_g_pkg.sv
// -----------------------------------------------------------------------------
// b_g_pkg
//   Shared constants and reference conversion functions for the b_g
//   binary-to-Gray block.
//
//   B_G_DEFAULT_WIDTH : default converter width.
//   B_G_MAX_WIDTH     : widest supported converter (the helper functions work
//                       on 32-bit containers, so narrower values are
//                       zero-extended into them).
//   bin2gray()        : reflected Gray encode, g = b ^ (b >> 1).
//   gray2bin()        : Gray decode (prefix XOR from the MSB down). The
//                       optional self-checker uses it.
//
//   Zero-extension is safe for both functions: leading zeros in the binary
//   value map to leading zeros in the Gray value, and the reverse also holds.
// -----------------------------------------------------------------------------
package b_g_pkg;

  localparam int B_G_DEFAULT_WIDTH = 3;
  localparam int B_G_MAX_WIDTH     = 32;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/b_g_if.sv
// -----------------------------------------------------------------------------
// b_g_if
//   Interface that bundles the data and valid signals of b_g.
//
//   in_valid  : qualifies B this cycle (master -> slave)
//   B         : binary input value, WIDTH bits (master -> slave)
//   out_valid : G was updated on the last edge (slave -> master)
//   G         : registered Gray code of the last valid B (slave -> master)
//   chk_err   : sticky self-check error. This signal exists only when
//               B_G_CHECK_EN is defined (slave -> master).
//
//   Modports:
//     master : the producer of B and consumer of G (the testbench or the
//              surrounding logic).
//     slave  : the b_g block itself.
// -----------------------------------------------------------------------------
interface b_g_if #(
  parameter int WIDTH = b_g_pkg::B_G_DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] G;
`ifdef B_G_CHECK_EN
  logic             chk_err;
`endif

`ifdef B_G_CHECK_EN
  modport master (output in_valid, output B,
                  input  out_valid, input G, input chk_err);
  modport slave  (input  in_valid, input B,
                  output out_valid, output G, output chk_err);
`else
  modport master (output in_valid, output B,
                  input  out_valid, input G);
  modport slave  (input  in_valid, input B,
                  output out_valid, output G);
`endif

endinterface

// File: rtl/b_g_core.sv
// -----------------------------------------------------------------------------
// b_g_core
//   Purely combinational binary-to-Gray converter of width WIDTH.
//
//   b : binary input, WIDTH bits
//   g : reflected Gray code of b, WIDTH bits
//
//   The MSB passes straight through. Every lower bit is the XOR of its binary
//   bit and the next higher binary bit. The logic has no carry chain, so the
//   delay stays at a single XOR level for any WIDTH.
// -----------------------------------------------------------------------------
module b_g_core #(
  parameter int WIDTH = b_g_pkg::B_G_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  assign g[WIDTH-1] = b[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign g[i] = b[i+1] ^ b[i];
  end

endmodule

// File: rtl/b_g.sv
// -----------------------------------------------------------------------------
// b_g
//   Binary-to-Gray converter with a registered output stage. A value on bus.B
//   qualified by bus.in_valid is converted and appears on bus.G one clock
//   later, with bus.out_valid set high. The block has no backpressure and
//   accepts one value per clock.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset. It clears G, out_valid and
//             chk_err.
//     bus   : b_g_if.slave (in_valid, B -> out_valid, G [, chk_err])
//
//   Optional feature macro: B_G_CHECK_EN
//     When B_G_CHECK_EN is defined, a shadow register captures B together
//     with G. The registered G is then decoded back to binary and compared
//     with the shadow value. Any mismatch while out_valid is high sets the
//     sticky chk_err flag one clock later, and only reset clears it. When the
//     macro is undefined, the shadow register, the decoder and chk_err are
//     all absent.
//
//   All outputs come straight from flops, so no combinational path exists
//   from the inputs to the outputs.
// -----------------------------------------------------------------------------
module b_g
  import b_g_pkg::*;
#(
  parameter int WIDTH = B_G_DEFAULT_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  b_g_if.slave  bus
);

  localparam int STAGES = 1;

  logic [WIDTH-1:0]  g_next;
  logic [WIDTH-1:0]  g_q;
  logic [STAGES-1:0] vld_pipe;

  b_g_core #(.WIDTH(WIDTH)) u_core (
    .b (bus.B),
    .g (g_next)
  );

  // G loads only on a valid cycle. An X/Z value on B while in_valid is low
  // never reaches g_q, because the load enable gates it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q      <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.in_valid;
      if (bus.in_valid) g_q <= g_next;
    end
  end

  assign bus.G         = g_q;
  assign bus.out_valid = vld_pipe[STAGES-1];

`ifdef B_G_CHECK_EN
  logic [WIDTH-1:0] b_q;
  logic             chk_err_q;
  logic [31:0]      g_dec;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
    end else if (bus.in_valid) begin
      b_q <= bus.B;
    end
  end

  // The comparison uses the full 32-bit width. Both sides are zero-extended,
  // so the upper bits match by construction and every bit takes part.
  assign g_dec    = gray2bin(32'(g_q));
  assign mismatch = vld_pipe[STAGES-1] && (g_dec != 32'(b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_q | mismatch;
    end
  end

  assign bus.chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_b_g.sv
// -----------------------------------------------------------------------------
// tb_b_g
//   Self-checking bench for b_g. It instantiates a WIDTH=3 DUT and a WIDTH=8
//   DUT. Each stimulus step pushes the expected Gray code into a queue when it
//   drives a valid input. The bench pops that value and compares it after the
//   next rising edge.
//   Define B_G_CHECK_EN to also exercise the self-check flag.
// -----------------------------------------------------------------------------
module tb_b_g;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  b_g_if #(.WIDTH(3)) bus3 ();
  b_g_if #(.WIDTH(8)) bus8 ();

  b_g #(.WIDTH(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  b_g #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int cmps = 0;
  int errs = 0;

  logic [2:0] q3[$];
  logic [7:0] q8[$];
  logic [2:0] held3;
  logic [7:0] held8;
  logic [7:0] prev8;

  function automatic logic [7:0] gray_model(input logic [7:0] b);
    logic [7:0] g;
    g = b ^ {1'b0, b[7:1]};
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, then check 1ns after the following rising edge.
  task automatic step3(input logic v, input logic [2:0] b, input string tag);
    logic [2:0] e;
    @(negedge clk);
    bus3.in_valid = v;
    bus3.B        = b;
    if (v) begin
      e = gray_model({5'b0, b})[2:0];
      q3.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, ".ov"}, {31'b0, bus3.out_valid}, {31'b0, v});
    if (v) begin
      if (q3.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        held3 = q3.pop_front();
      end
    end
    chk({tag, ".G"}, {29'b0, bus3.G}, {29'b0, held3});
  endtask

  task automatic step8(input logic v, input logic [7:0] b, input string tag);
    @(negedge clk);
    bus8.in_valid = v;
    bus8.B        = b;
    if (v) q8.push_back(gray_model(b));
    @(posedge clk);
    #1;
    chk({tag, ".ov8"}, {31'b0, bus8.out_valid}, {31'b0, v});
    if (v && q8.size() != 0) held8 = q8.pop_front();
    chk({tag, ".G8"}, {24'b0, bus8.G}, {24'b0, held8});
  endtask

  logic [2:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 3'b000; sweep_exp[1] = 3'b001; sweep_exp[2] = 3'b011; sweep_exp[3] = 3'b010;
    sweep_exp[4] = 3'b110; sweep_exp[5] = 3'b111; sweep_exp[6] = 3'b101; sweep_exp[7] = 3'b100;
    held3 = '0;
    held8 = '0;

    // Reset held low while valid random data is driven.
    rst_n         = 1'b0;
    bus3.in_valid = 1'b1;
    bus3.B        = 3'($urandom);
    bus8.in_valid = 1'b1;
    bus8.B        = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst.G",   {29'b0, bus3.G}, 32'd0);
      chk("rst.ov",  {31'b0, bus3.out_valid}, 32'd0);
      chk("rst.G8",  {24'b0, bus8.G}, 32'd0);
      bus3.B = 3'($urandom);
      bus8.B = 8'($urandom);
    end
    @(negedge clk);
    bus3.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    rst_n = 1'b1;

    // Exhaustive WIDTH=3 sweep, back to back, cross-checked against the table.
    for (int i = 0; i < 8; i++) begin
      step3(1'b1, 3'(i), "sweep");
      chk("sweep.tbl", {29'b0, bus3.G}, {29'b0, sweep_exp[i]});
    end
    // Wrap 111 -> 000: a single-bit change.
    step3(1'b1, 3'b000, "wrap");
    chk("wrap.onebit", $countones(bus3.G ^ 3'b100), 32'd1);

    // Hold with X on B while invalid.
    step3(1'b1, 3'b101, "hold.load");
    chk("hold.load.tbl", {29'b0, bus3.G}, 32'b111);
    for (int i = 0; i < 3; i++) begin
      step3(1'b0, 3'bxxx, "hold");
      chk("hold.tbl", {29'b0, bus3.G}, 32'b111);
    end

    // Mid-stream asynchronous reset.
    step3(1'b1, 3'b010, "mid.a");
    step3(1'b1, 3'b011, "mid.b");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.rst.G",  {29'b0, bus3.G}, 32'd0);
    chk("mid.rst.ov", {31'b0, bus3.out_valid}, 32'd0);
    q3.delete();
    held3 = '0;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    rst_n = 1'b1;
    step3(1'b1, 3'b110, "mid.after");
    chk("mid.after.tbl", {29'b0, bus3.G}, 32'b101);

    // WIDTH=8: boundary codes plus a single-bit-change check across counts.
    step8(1'b1, 8'hFF, "w8.ff");
    chk("w8.ff.tbl", {24'b0, bus8.G}, 32'h80);
    step8(1'b1, 8'h80, "w8.80");
    chk("w8.80.tbl", {24'b0, bus8.G}, 32'hC0);
    step8(1'b1, 8'h77, "w8.cnt");
    prev8 = bus8.G;
    for (int i = 8'h78; i <= 8'h88; i++) begin
      step8(1'b1, 8'(i), "w8.cnt");
      chk("w8.onebit", $countones(bus8.G ^ prev8), 32'd1);
      prev8 = bus8.G;
    end
    step8(1'b1, 8'hFF, "w8.wrap.a");
    step8(1'b1, 8'h00, "w8.wrap.b");
    chk("w8.wrap.onebit", $countones(bus8.G ^ 8'h80), 32'd1);
    step8(1'b0, 8'h5A, "w8.idle");

`ifdef B_G_CHECK_EN
    // A correct sweep must leave the checker quiet.
    for (int i = 0; i < 8; i++) begin
      step3(1'b1, 3'(i), "chk.sweep");
      chk("chk.sweep.err", {31'b0, bus3.chk_err}, 32'd0);
    end
    step3(1'b1, 3'b101, "chk.pre");
    // Corrupt G while out_valid is high, so the flag must set and stick.
    force dut.g_q = 3'b110;
    @(posedge clk);
    #1;
    chk("chk.set", {31'b0, bus3.chk_err}, 32'd1);
    release dut.g_q;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("chk.sticky", {31'b0, bus3.chk_err}, 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("chk.rst", {31'b0, bus3.chk_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/b_g.md
# b_g

Parameterized binary-to-Gray code converter with a registered output stage. Binary values presented on `B` with `in_valid` are converted to reflected Gray code and registered onto `G` one clock later. The block is a leaf datapath element, used wherever a counter or pointer value must cross into a Gray-coded domain, such as FIFO pointers or encoder outputs.

## Interface
- `WIDTH`, default 3: bit width of `B` and `G`; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  qualifies `B` this cycle.
- `B`  in  WIDTH  binary input value.
- `out_valid`  out  1  `G` updated on the last edge.
- `G`  out  WIDTH  registered Gray code of the last valid `B`.
- `chk_err`  out  1  self-check mismatch; present only with `B_G_CHECK_EN`.

## Operation
- Conversion: G[WIDTH-1] = B[WIDTH-1]; G[i] = B[i+1] XOR B[i] for i = WIDTH-2..0. Equivalently, G = B XOR (B >> 1).
- Pure bitwise logic; no arithmetic or carries. All 2^WIDTH codes are legal.
- When `in_valid`=1 at a rising edge, `G` loads the converted value and `out_valid` goes to 1.
- When `in_valid`=0 at a rising edge, `G` holds its previous value and `out_valid` goes to 0.
- No backpressure; the block accepts one value every cycle.
- Back-to-back valid inputs produce back-to-back outputs with no bubbles.
- Wrap-around: all-ones binary maps to 1 followed by zeros (e.g. 111 -> 100). The next count, 000, maps to 000, a single-bit change.
- X or Z on `B` while `in_valid`=0 must not propagate to `G`.

## Timing
- Latency is 1 clock from `in_valid`/`B` sampled to `G`/`out_valid`; throughput is 1 per clock.
- Reset (`rst_n`=0) immediately and asynchronously forces `G`=0, `out_valid`=0 and `chk_err`=0, independent of `clk`.
- Reset asserted mid-stream discards any in-flight value.
- After `rst_n` deasserts, the first rising edge with `in_valid`=1 loads normally. No synchronizer is required inside the block.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.

## Configuration
- `B_G_CHECK_EN` defined:
  - A second register captures `B` alongside `G`.
  - A Gray-to-binary inverse (b[MSB]=g[MSB]; b[i]=b[i+1] XOR g[i]) runs on `G` and is compared to the captured `B`.
  - `chk_err` registers 1 on the cycle after any mismatch while `out_valid`=1, and is sticky until reset.
- `B_G_CHECK_EN` undefined: the `chk_err` port, the shadow register and the inverse logic are absent.

## Structure
- Package `b_g_pkg` holds:
  - `B_G_DEFAULT_WIDTH` = 3.
  - Function `bin2gray(logic [31:0])`.
  - Function `gray2bin(logic [31:0])`, used by the checker.
- One natural sub-module, `b_g_core`: the purely combinational WIDTH-parameterized converter, instantiated by `b_g` in front of the output register.

## Test plan
- Reset: hold `rst_n`=0 with random `B` and `in_valid`=1 -> `G`=000, `out_valid`=0 throughout.
- Exhaustive sweep, WIDTH=3: drive `B` = 000,001,010,011,100,101,110,111 one per clock with `in_valid`=1 -> `G` = 000,001,011,010,110,111,101,100, each one clock later, with `out_valid`=1.
- Hold: `B`=101 valid, then `in_valid`=0 with `B`=XXX for 3 cycles -> `G` stays 111, `out_valid`=0.
- Mid-stream reset: stream 010,011; assert `rst_n` low between clock edges -> `G`=000 and `out_valid`=0 immediately; after release, `B`=110 -> `G`=101.
- WIDTH=8: `B`=0xFF -> `G`=0x80; `B`=0x80 -> `G`=0xC0; successive counts differ in exactly one bit of `G`.
- With `B_G_CHECK_EN`: full sweep -> `chk_err` stays 0. Force a `G` bit via testbench `force` -> `chk_err`=1 the next cycle and remains 1 until reset.
